ddr_app_responder: RTL and testbench

DDR_APP_RESPONDER -- requirements
Module: ddr_app_responder

---
 rtl/ddr_app_responder.sv | 193 +++++++++++++++++++
 tb/tb_ddr_app_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_app_responder.sv
// DDR app-interface responder: BL8-word backing store, 4-beat write FIFO, optional refresh stall (DDR_REFRESH_STALL_EN).
// Reads return RD_LATENCY cycles after accept; app_rdy drops while a write awaits data, app_wdf_rdy drops when the FIFO is full.
module ddr_app_responder #(
    parameter int ADDR_WIDTH   = 28,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH_LOG2   = 10,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  app_en,
    input  logic [2:0]            app_cmd,
    input  logic [ADDR_WIDTH-1:0] app_addr,
    output logic                  app_rdy,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    input  logic [DATA_WIDTH-1:0] app_wdf_data,
    output logic                  app_wdf_rdy,
    output logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  init_calib_complete,
    output logic [1:0]            err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CALIB_CYCLES + 1);

    typedef enum logic {S_IDLE, S_WAIT_DATA} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_calib_cnt;
    logic                    r_calib;
    logic                    w_stall;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_fifo_dat [4];
    logic [1:0]              r_wr_ptr, r_rd_ptr;
    logic [2:0]              r_count;
    logic [DEPTH_LOG2-1:0]   r_wait_idx;
    logic [RD_LATENCY-1:0]   r_pipe_vld;
    logic [DATA_WIDTH-1:0]   r_pipe_dat [RD_LATENCY];
    logic [1:0]              r_err;

    logic                    w_cmd_acc, w_beat_acc, w_is_wr, w_is_rd, w_is_bad, w_rd_acc;
    logic                    w_fifo_empty, w_fifo_full;
    logic                    w_commit, w_pop, w_push, w_bypass;
    logic [DEPTH_LOG2-1:0]   w_cmd_idx, w_commit_idx;
    logic [DATA_WIDTH-1:0]   w_commit_dat;
    logic                    w_unused_addr;

    // Low 3 address bits select the beat inside a BL8 burst; bits above the store alias.
    assign w_cmd_idx     = app_addr[DEPTH_LOG2+2:3];
    assign w_unused_addr = ^{app_addr[2:0], app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_calib_cnt <= '0;
            r_calib     <= 1'b0;
        end else if (!r_calib) begin
            if (r_calib_cnt == CW'(CALIB_CYCLES - 1))
                r_calib <= 1'b1;
            else
                r_calib_cnt <= r_calib_cnt + 1'b1;
        end
    end

`ifdef DDR_REFRESH_STALL_EN
    logic [7:0] r_ref_cnt;
    logic       r_ref_armed;

    // First window opens once 256 calibrated cycles have elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt   <= '0;
            r_ref_armed <= 1'b0;
        end else if (r_calib) begin
            r_ref_cnt <= r_ref_cnt + 8'd1;
            if (r_ref_cnt == 8'hFF)
                r_ref_armed <= 1'b1;
        end
    end

    assign w_stall = r_ref_armed && (r_ref_cnt < 8'd8);
`else
    assign w_stall = 1'b0;
`endif

    assign w_fifo_empty = (r_count == 3'd0);
    assign w_fifo_full  = (r_count == 3'd4);

    assign app_rdy             = r_calib && (r_state == S_IDLE) && !w_stall;
    assign app_wdf_rdy         = r_calib && !w_fifo_full;
    assign init_calib_complete = r_calib;
    assign err                 = r_err;

    assign w_cmd_acc  = app_en && app_rdy;
    assign w_beat_acc = app_wdf_wren && app_wdf_rdy;
    assign w_is_wr    = (app_cmd == 3'b000);
    assign w_is_rd    = (app_cmd == 3'b001);
    assign w_is_bad   = !w_is_wr && !w_is_rd;
    assign w_rd_acc   = w_cmd_acc && w_is_rd;

    always_comb begin
        w_state_nxt  = r_state;
        w_commit     = 1'b0;
        w_commit_idx = w_cmd_idx;
        w_commit_dat = app_wdf_data;
        w_pop        = 1'b0;
        w_bypass     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc && w_is_wr) begin
                    if (!w_fifo_empty) begin
                        w_commit     = 1'b1;
                        w_commit_dat = r_fifo_dat[r_rd_ptr];
                        w_pop        = 1'b1;
                    end else if (w_beat_acc) begin
                        w_commit = 1'b1;
                        w_bypass = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                w_commit_idx = r_wait_idx;
                if (!w_fifo_empty) begin
                    w_commit     = 1'b1;
                    w_commit_dat = r_fifo_dat[r_rd_ptr];
                    w_pop        = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (w_beat_acc) begin
                    w_commit    = 1'b1;
                    w_bypass    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_push = w_beat_acc && !w_bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wait_idx <= '0;
            r_err      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            if (w_cmd_acc)
                r_wait_idx <= w_cmd_idx;
            r_err <= r_err | {w_beat_acc && !app_wdf_end, w_cmd_acc && w_is_bad};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo_dat[r_wr_ptr] <= app_wdf_data;
        if (w_commit)
            r_mem[w_commit_idx] <= w_commit_dat;
    end

    // Invalid stages carry zero so the read bus idles at zero without an output mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++)
                r_pipe_dat[i] <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            r_pipe_dat[0] <= w_rd_acc ? r_mem[w_cmd_idx] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    assign app_rd_data_valid = r_pipe_vld[RD_LATENCY-1];
    assign app_rd_data_end   = r_pipe_vld[RD_LATENCY-1];
    assign app_rd_data       = r_pipe_dat[RD_LATENCY-1];

endmodule

// File: tb/tb_ddr_app_responder.sv
// Randomized + directed bench for ddr_app_responder against a queue/array model of the app interface.
module tb_ddr_app_responder;

    localparam int AW  = 28;
    localparam int DW  = 64;
    localparam int DL  = 10;
    localparam int RL  = 4;
    localparam int CAL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;
    logic          init_calib_complete;
    logic [1:0]    err;

    always #5 clk = ~clk;

    ddr_app_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL),
        .RD_LATENCY(RL), .CALIB_CYCLES(CAL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end),
        .init_calib_complete(init_calib_complete), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] dat;
    } rd_t;

    logic [DW-1:0] m_mem [int];
    logic [DW-1:0] m_fifo [$];
    rd_t           m_rdq [$];
    bit            m_wait;
    int            m_wait_idx;
    logic [1:0]    m_err;
    int            cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int word_idx(input logic [AW-1:0] a);
        return int'(a / 8) % (1 << DL);
    endfunction

    function automatic bit m_stall();
`ifdef DDR_REFRESH_STALL_EN
        return (cyc >= CAL + 256) && (((cyc - CAL) % 256) < 8);
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle();
        app_en = 1'b0; app_cmd = 3'b000; app_addr = '0;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0;
    endtask

    // Compare all outputs for the current cycle, then advance the model across the next clock edge.
    task automatic cycle();
        bit            cal, exp_rdy, exp_wrdy, cacc, bacc, used;
        logic [DW-1:0] exp_dat;
        bit            exp_vld;
        rd_t           r;
        int            idx;
        cal      = (cyc >= CAL);
        exp_rdy  = cal && !m_wait && !m_stall();
        exp_wrdy = cal && (m_fifo.size() < 4);
        exp_vld  = 1'b0;
        exp_dat  = '0;
        if (m_rdq.size() > 0 && m_rdq[0].due == cyc) begin
            exp_vld = 1'b1;
            exp_dat = m_rdq[0].dat;
            void'(m_rdq.pop_front());
        end
        chk("calib", init_calib_complete, cal);
        chk("app_rdy", app_rdy, exp_rdy);
        chk("app_wdf_rdy", app_wdf_rdy, exp_wrdy);
        chk("rd_valid", app_rd_data_valid, exp_vld);
        chk("rd_end", app_rd_data_end, exp_vld);
        chk("rd_data", app_rd_data, exp_dat);
        chk("err", err, m_err);

        cacc = app_en && exp_rdy;
        bacc = app_wdf_wren && exp_wrdy;
        used = 1'b0;
        idx  = word_idx(app_addr);
        if (bacc && !app_wdf_end)
            m_err[1] = 1'b1;
        if (cacc) begin
            if (app_cmd == 3'b001) begin
                r.due = cyc + RL;
                r.dat = m_mem.exists(idx) ? m_mem[idx] : '0;
                m_rdq.push_back(r);
            end else if (app_cmd == 3'b000) begin
                if (m_fifo.size() > 0) begin
                    m_mem[idx] = m_fifo.pop_front();
                end else if (bacc) begin
                    m_mem[idx] = app_wdf_data;
                    used = 1'b1;
                end else begin
                    m_wait = 1'b1;
                    m_wait_idx = idx;
                end
            end else begin
                m_err[0] = 1'b1;
            end
        end else if (m_wait && bacc) begin
            m_mem[m_wait_idx] = app_wdf_data;
            m_wait = 1'b0;
            used = 1'b1;
        end
        if (bacc && !used)
            m_fifo.push_back(app_wdf_data);
        cyc++;
        @(negedge clk);
    endtask

    // Entered at a falling edge; reset is asserted mid-cycle to show it acts asynchronously.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_app_rdy", app_rdy, 0);
        chk("rst_wdf_rdy", app_wdf_rdy, 0);
        chk("rst_valid", app_rd_data_valid, 0);
        chk("rst_end", app_rd_data_end, 0);
        chk("rst_data", app_rd_data, 0);
        chk("rst_calib", init_calib_complete, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_fifo.delete();
        m_rdq.delete();
        m_mem.delete();
        m_wait = 1'b0;
        m_err  = 2'b00;
        cyc    = 0;
    endtask

    task automatic calibrate();
        for (int i = 0; i < CAL; i++) begin
            if (i == 0) chk("precal_app_rdy", app_rdy, 0);
            if (i == CAL - 1) chk("calib_cycle15", init_calib_complete, 0);
            cycle();
        end
        chk("calib_cycle16", init_calib_complete, 1);
        chk("app_rdy_cycle16", app_rdy, 1);
    endtask

    initial begin
        logic [63:0]   e;
        logic [AW-1:0] a;
        int            slot, r;
        idle();
        m_wait = 1'b0; m_err = 2'b00; cyc = 0;
        @(negedge clk);
        do_reset();
        calibrate();

        // Write with same-cycle beat, read next cycle.
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h40;
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = 64'hDEADBEEF;
        cycle();
        app_wdf_wren = 1'b0; app_cmd = 3'b001;
        cycle();
        idle();
        for (int i = 1; i < RL; i++) begin
            chk("rd_not_early", app_rd_data_valid, 0);
            cycle();
        end
        chk("rd_lat_valid", app_rd_data_valid, 1);
        chk("rd_lat_end", app_rd_data_end, 1);
        chk("rd_lat_data", app_rd_data, 64'hDEADBEEF);
        cycle();

        // Write command ahead of its data.
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h80;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("rdy_wait_data", app_rdy, 0);
            cycle();
        end
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = 64'h1234;
        chk("rdy_beat_cycle", app_rdy, 0);
        cycle();
        idle();
        chk("rdy_after_beat", app_rdy, 1);
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h80;
        cycle();
        idle();
        repeat (RL - 1) cycle();
        chk("late_beat_valid", app_rd_data_valid, 1);
        chk("late_beat_data", app_rd_data, 64'h1234);
        cycle();

        // Beats ahead of commands: fifth stalls, then drain and read back.
        for (int i = 0; i < 5; i++) begin
            app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = 64'h101 + 64'(i);
            chk(i == 4 ? "wdf_rdy_full" : "wdf_rdy_room", app_wdf_rdy, (i == 4) ? 0 : 1);
            cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            app_en = 1'b1; app_cmd = 3'b000; app_addr = AW'(i * 8);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            app_en = 1'b1; app_cmd = 3'b001; app_addr = AW'(i * 8);
            cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            e = 64'h101 + 64'(i);
            chk("fifo_order_valid", app_rd_data_valid, 1);
            chk("fifo_order_data", app_rd_data, e);
            cycle();
        end

        // Error flags.
        app_en = 1'b1; app_cmd = 3'b111; app_addr = 28'h40;
        cycle();
        idle();
        chk("err_bad_cmd", err, 2'b01);
        repeat (RL + 1) cycle();
        app_wdf_wren = 1'b1; app_wdf_end = 1'b0; app_wdf_data = 64'hABC;
        cycle();
        idle();
        chk("err_no_end", err, 2'b11);
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h100;
        cycle();
        idle();

        // Randomized traffic over 16 word slots with aliasing upper/lower address bits.
        for (int n = 0; n < 3000; n++) begin
            idle();
            slot = $urandom_range(0, 15);
            a = AW'($urandom);
            a[12:3] = 10'(slot);
            app_addr = a;
            r = $urandom_range(0, 99);
            app_en = ($urandom_range(0, 1) == 1);
            if (r < 45 || (r < 97 && !m_mem.exists(slot)))
                app_cmd = 3'b000;
            else if (r < 97)
                app_cmd = 3'b001;
            else
                app_cmd = 3'($urandom_range(2, 7));
            app_wdf_wren = ($urandom_range(0, 1) == 1);
            app_wdf_end  = ($urandom_range(0, 19) != 0);
            app_wdf_data = {$urandom, $urandom};
            cycle();
        end
        idle();

        // Reset with reads and a write in flight.
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h40;
        if (m_mem.exists(8)) cycle();
        app_cmd = 3'b000;
        cycle();
        idle();
        do_reset();
        calibrate();

`ifdef DDR_REFRESH_STALL_EN
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h40;
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = 64'h55;
        cycle();
        idle();
        while (cyc < CAL + 255) cycle();
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h40;
        chk("ref_rdy_255", app_rdy, 1);
        cycle();
        idle();
        for (int k = 256; k < 264; k++) begin
            chk("ref_stall", app_rdy, 0);
            if (k == 259) begin
                chk("ref_rd_valid", app_rd_data_valid, 1);
                chk("ref_rd_data", app_rd_data, 64'h55);
            end
            cycle();
        end
        chk("ref_rdy_264", app_rdy, 1);
`else
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h200;
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = 64'hCAFE;
        cycle();
        idle();
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h200;
        cycle();
        idle();
        repeat (RL - 1) cycle();
        chk("post_rst_data", app_rd_data, 64'hCAFE);
        chk("post_rst_err", err, 2'b00);
        for (int i = 0; i < 300; i++) begin
            chk("no_refresh_stall", app_rdy, 1);
            cycle();
        end
`endif
        repeat (RL + 2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
